// File: rtl/imm_extend_pipe_if.sv
// Decode-stage immediate bus: instruction/format request in, extended immediate out.
// The producer side uses 'master' and the extender uses 'slave'.
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:7]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immext;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immext, out_tag, illegal
    );

    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immext, out_tag, illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a main register and a skid register.
// in_ready comes straight from the skid valid flop, so it never sees out_ready.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input logic              clk,
    input logic              reset,
    imm_extend_pipe_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    entry_t dec;
    entry_t m_q, m_d, k_q, k_d;
    logic   m_vld_q, m_vld_d, k_vld_q, k_vld_d;
    logic   push, pop;

    always_comb begin
        dec     = '0;
        dec.tag = bus.in_tag;
        case (bus.immsrc)
            3'b000: dec.imm = XLEN'($signed(bus.instr[31:20]));
            3'b001: dec.imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            3'b010: dec.imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                              bus.instr[11:8], 1'b0}));
            3'b011: dec.imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                              bus.instr[30:21], 1'b0}));
            3'b100: dec.imm = XLEN'($signed({bus.instr[31:12], 12'b0}));
            // RV64 shift amounts take one more bit.
            3'b101: dec.imm = (XLEN == 32) ? XLEN'(bus.instr[24:20]) : XLEN'(bus.instr[25:20]);
            3'b110: dec.imm = XLEN'(bus.instr[19:15]);
            default: dec.ill = 1'b1;
        endcase
    end

    assign pop  = m_vld_q && bus.out_ready;
    assign push = bus.in_valid && !k_vld_q;

    always_comb begin
        m_d     = m_q;
        k_d     = k_q;
        m_vld_d = m_vld_q;
        k_vld_d = k_vld_q;
        if (pop && k_vld_q) begin
            m_d     = k_q;
            k_vld_d = 1'b0;
        end else if (push && (!m_vld_q || pop)) begin
            m_d     = dec;
            m_vld_d = 1'b1;
        end else if (push) begin
            k_d     = dec;
            k_vld_d = 1'b1;
        end else if (pop) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q     <= '0;
            k_q     <= '0;
            m_vld_q <= 1'b0;
            k_vld_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            k_q     <= k_d;
            m_vld_q <= m_vld_d;
            k_vld_q <= k_vld_d;
        end
    end

    assign bus.in_ready  = !k_vld_q;
    assign bus.out_valid = m_vld_q;
    assign bus.immext    = m_q.imm;
    assign bus.out_tag   = m_q.tag;
    assign bus.illegal   = m_q.ill;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized checks of imm_extend_pipe at XLEN=32 and XLEN=64.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

    imm_extend_pipe #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    imm_extend_pipe #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [7:0] tag);
        b32.in_valid = v;
        b32.instr    = ins[31:7];
        b32.immsrc   = src;
        b32.in_tag   = tag;
    endtask

    task automatic put64(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [7:0] tag);
        b64.in_valid = v;
        b64.instr    = ins[31:7];
        b64.immsrc   = src;
        b64.in_tag   = tag;
    endtask

    // Reference RV32 extender, built from the ISA field layouts.
    function automatic logic [32:0] ref32(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'd0: return {1'b0, {20{i[31]}}, i[31:20]};
            3'd1: return {1'b0, {20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {1'b0, {20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {1'b0, {12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            3'd4: return {1'b0, i[31:12], 12'b0};
            3'd5: return {1'b0, 27'b0, i[24:20]};
            3'd6: return {1'b0, 27'b0, i[19:15]};
            default: return {1'b1, 32'b0};
        endcase
    endfunction

    logic [31:0] tv_ins [9] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'h001000EF,
                                32'h123450B7, 32'h01F0D093, 32'h03F01093, 32'h3407D073,
                                32'hFFFFFFFF};
    logic [2:0]  tv_src [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic [31:0] tv_exp [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000008, 32'h00000800,
                                32'h12345000, 32'h0000001F, 32'h0000001F, 32'h0000000F,
                                32'h00000000};
    logic        tv_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [40:0] q [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        put32(1'b0, 32'h0, 3'd0, 8'h0);
        put64(1'b0, 32'h0, 3'd0, 8'h0);
        b32.out_ready = 1'b1;
        b64.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", b32.out_valid, 0);
        chk("rst_in_ready",  b32.in_ready,  1);
        chk("rst_immext",    b32.immext,    0);
        chk("rst_out_tag",   b32.out_tag,   0);
        chk("rst_illegal",   b32.illegal,   0);
        chk("rst64_immext",  b64.immext,    0);
        cyc();
        reset = 1'b0;

        // Back-to-back formats: input held valid every cycle, one result per cycle.
        for (int n = 0; n < 9; n++) begin
            put32(1'b1, tv_ins[n], tv_src[n], 8'(n + 1));
            cyc();
            chk($sformatf("b2b_valid_%0d", n), b32.out_valid, 1);
            chk($sformatf("b2b_imm_%0d", n),   b32.immext,    tv_exp[n]);
            chk($sformatf("b2b_tag_%0d", n),   b32.out_tag,   n + 1);
            chk($sformatf("b2b_ill_%0d", n),   b32.illegal,   tv_ill[n]);
            chk($sformatf("b2b_rdy_%0d", n),   b32.in_ready,  1);
        end
        b32.in_valid = 1'b0;
        cyc();
        chk("b2b_drain", b32.out_valid, 0);

        // Backpressure: M then K fill, in_ready drops, data held until release.
        b32.out_ready = 1'b0;
        put32(1'b1, 32'hFFF00093, 3'd0, 8'd1);
        cyc();
        chk("bp1_tag", b32.out_tag, 1);
        chk("bp1_rdy", b32.in_ready, 1);
        put32(1'b1, 32'h00000463, 3'd2, 8'd2);
        cyc();
        chk("bp2_rdy", b32.in_ready, 0);
        chk("bp2_tag", b32.out_tag, 1);
        put32(1'b1, 32'h123450B7, 3'd4, 8'd3);
        cyc();
        cyc();
        chk("bp_hold_imm", b32.immext, 32'hFFFFFFFF);
        chk("bp_hold_tag", b32.out_tag, 1);
        chk("bp_hold_rdy", b32.in_ready, 0);
        b32.out_ready = 1'b1;
        cyc();
        chk("bp_out2_tag", b32.out_tag, 2);
        chk("bp_out2_imm", b32.immext, 32'h00000008);
        chk("bp_out2_rdy", b32.in_ready, 1);
        cyc();
        b32.in_valid = 1'b0;
        chk("bp_out3_tag", b32.out_tag, 3);
        chk("bp_out3_imm", b32.immext, 32'h12345000);
        cyc();
        chk("bp_empty", b32.out_valid, 0);

        // RV64 widths.
        put64(1'b1, 32'hFFF00093, 3'd0, 8'h11);
        cyc();
        chk("x64_i_imm", b64.immext, 64'hFFFFFFFFFFFFFFFF);
        chk("x64_i_tag", b64.out_tag, 8'h11);
        put64(1'b1, 32'h800000B7, 3'd4, 8'h12);
        cyc();
        chk("x64_u_imm", b64.immext, 64'hFFFFFFFF80000000);
        put64(1'b1, 32'h03F01093, 3'd5, 8'h13);
        cyc();
        chk("x64_shamt_imm", b64.immext, 64'h3F);
        chk("x64_shamt_ill", b64.illegal, 0);
        b64.in_valid = 1'b0;
        cyc();
        chk("x64_drain", b64.out_valid, 0);

        // Asynchronous reset with both registers full.
        b32.out_ready = 1'b0;
        put32(1'b1, 32'hFFF00093, 3'd0, 8'h21);
        cyc();
        put32(1'b1, 32'hFE20AE23, 3'd1, 8'h22);
        cyc();
        b32.in_valid = 1'b0;
        chk("ar_full_rdy", b32.in_ready, 0);
        chk("ar_full_vld", b32.out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", b32.out_valid, 0);
        chk("ar_in_ready",  b32.in_ready,  1);
        chk("ar_immext",    b32.immext,    0);
        chk("ar_out_tag",   b32.out_tag,   0);
        #2 reset = 1'b0;
        b32.out_ready = 1'b1;
        put32(1'b1, 32'h123450B7, 3'd4, 8'h23);
        cyc();
        b32.in_valid = 1'b0;
        chk("ar_new_vld", b32.out_valid, 1);
        chk("ar_new_tag", b32.out_tag, 8'h23);
        chk("ar_new_imm", b32.immext, 32'h12345000);
        cyc();
        chk("ar_alone", b32.out_valid, 0);

        // Random valid/ready stress against a queue model.
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] ins;
            logic [2:0]  src;
            logic        psh, pp;
            chk("rnd_in_ready",  b32.in_ready,  q.size() < 2);
            chk("rnd_out_valid", b32.out_valid, q.size() > 0);
            if (q.size() > 0)
                chk("rnd_data", {b32.immext, b32.out_tag, b32.illegal}, q[0]);
            ins = $urandom;
            src = 3'($urandom_range(0, 7));
            put32(1'($urandom_range(0, 1)), ins, src, 8'(c));
            b32.out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_rdy_indep", b32.in_ready, q.size() < 2);
            psh = b32.in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && b32.out_ready;
            if (pp) void'(q.pop_front());
            if (psh) begin
                logic [32:0] r;
                r = ref32(ins, src);
                q.push_back({r[31:0], 8'(c), r[32]});
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
